// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - registered MIPS main control with load-use stall and halt sequencing
//
// Purpose: decodes opcode/funct in ID and registers the WB/MEM/EX control buses
// and the jump/shift flags into ID/EX. Inserts bubbles on a load-use hazard,
// on a taken branch/jump flush, and while draining the pipe for HALT_OPCODE.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_opcode, i_funct         IF/ID instruction fields [31:26] / [5:0]
//   i_rs, i_rt                IF/ID source register specifiers
//   i_flush                   squash the instruction currently in ID
//   o_ctrl_wb/mem/exc_bus     ID/EX registered control buses
//   o_jump/jal/jr/jalr/shift  ID/EX registered flags
//   o_pc_write, o_ifid_write  combinational PC and IF/ID write enables
//   o_halted                  registered, high in the HALT state
//   o_illegal                 registered one-cycle trap on an unlisted opcode,
//                             present only when CTRL_ILLEGAL_TRAP_EN is defined
module control_pipe #(
  parameter int                   NB_OPCODE   = 6,
  parameter int                   NB_REG      = 5,
  parameter int                   NB_CTRL_EX  = 6,
  parameter int                   NB_CTRL_M   = 9,
  parameter int                   NB_CTRL_WB  = 2,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'h3F,
  parameter int                   DRAIN_CYC   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_OPCODE-1:0]  i_opcode,
  input  logic [NB_OPCODE-1:0]  i_funct,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic                  i_flush,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic                  o_jump,
  output logic                  o_jal,
  output logic                  o_jr,
  output logic                  o_jalr,
  output logic                  o_shift,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_halted
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                  o_illegal
`endif
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NB_CTRL_WB-1:0]   wb_q;
  logic [NB_CTRL_M-1:0]    mem_q;
  logic [NB_CTRL_EX-1:0]   ex_q;
  logic                    jump_q, jal_q, jr_q, jalr_q, shift_q;
  logic [NB_REG-1:0]       rt_ex_q;
  logic                    halted_q;

  logic [NB_CTRL_WB-1:0]   dec_wb;
  logic [NB_CTRL_M-1:0]    dec_mem;
  logic [NB_CTRL_EX-1:0]   dec_ex;
  logic                    dec_jump, dec_jal, dec_jr, dec_jalr, dec_shift, dec_legal;
  logic                    hazard, bubble, pc_write, ifid_write;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                    illegal_q, illegal_d;
`endif

  // Pure decode of the instruction in ID; unlisted opcodes fall out as all-zero.
  always_comb begin
    dec_wb    = '0;
    dec_mem   = '0;
    dec_ex    = '0;
    dec_jump  = 1'b0;
    dec_jal   = 1'b0;
    dec_jr    = 1'b0;
    dec_jalr  = 1'b0;
    dec_shift = 1'b0;
    dec_legal = 1'b1;
    case (i_opcode)
      6'h00: begin
        dec_wb = 2'b10;
        case (i_funct)
          6'h08: dec_jr = 1'b1;
          6'h09: begin dec_ex = 6'b000001; dec_jalr = 1'b1; end
          default: begin
            dec_ex    = 6'b000101;
            dec_shift = (i_funct == 6'h00) || (i_funct == 6'h02) || (i_funct == 6'h03);
          end
        endcase
      end
      6'h20: begin dec_wb = 2'b11; dec_mem = 9'b001000010; dec_ex = 6'b100000; end
      6'h21: begin dec_wb = 2'b11; dec_mem = 9'b000100010; dec_ex = 6'b100000; end
      6'h23: begin dec_wb = 2'b11; dec_mem = 9'b000000010; dec_ex = 6'b100000; end
      6'h27: begin dec_wb = 2'b11; dec_mem = 9'b000000010; dec_ex = 6'b100000; end
      6'h24: begin dec_wb = 2'b11; dec_mem = 9'b001010010; dec_ex = 6'b100000; end
      6'h25: begin dec_wb = 2'b11; dec_mem = 9'b000110010; dec_ex = 6'b100000; end
      6'h28: begin dec_mem = 9'b100000001; dec_ex = 6'b100000; end
      6'h29: begin dec_mem = 9'b010000001; dec_ex = 6'b100000; end
      6'h2B: begin dec_mem = 9'b000000001; dec_ex = 6'b100000; end
      6'h08: begin dec_wb = 2'b10; dec_ex = 6'b100110; end
      6'h0C: begin dec_wb = 2'b10; dec_ex = 6'b101000; end
      6'h0D: begin dec_wb = 2'b10; dec_ex = 6'b101010; end
      6'h0E: begin dec_wb = 2'b10; dec_ex = 6'b101100; end
      6'h0F: begin dec_wb = 2'b10; dec_ex = 6'b101110; end
      6'h0A: begin dec_wb = 2'b10; dec_ex = 6'b110000; end
      6'h04: begin dec_mem = 9'b000000100; dec_ex = 6'b100010; end
      6'h05: begin dec_mem = 9'b000001000; dec_ex = 6'b100010; end
      6'h02: dec_jump = 1'b1;
      6'h03: begin dec_wb = 2'b10; dec_jal = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  // A load in EX whose destination feeds the instruction in ID; $zero never stalls.
  assign hazard = mem_q[1] && (rt_ex_q != '0) && ((rt_ex_q == i_rs) || (rt_ex_q == i_rt));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bubble     = 1'b1;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d  = 1'b0;
`endif
    case (state_q)
      S_RUN: begin
        if (i_flush) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end else if (hazard) begin
          // stall one cycle; the bubble clears MemRead so ID re-decodes next cycle
        end else if (i_opcode == HALT_OPCODE) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC - 1);
        end else begin
          bubble     = 1'b0;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_d  = !dec_legal;
`endif
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_HALT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_HALT: ;
      default: state_d = S_RUN;
    endcase
    // keep fetch running while reset is asserted
    if (i_rst) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      wb_q     <= '0;
      mem_q    <= '0;
      ex_q     <= '0;
      jump_q   <= 1'b0;
      jal_q    <= 1'b0;
      jr_q     <= 1'b0;
      jalr_q   <= 1'b0;
      shift_q  <= 1'b0;
      rt_ex_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_q     <= bubble ? '0 : dec_wb;
      mem_q    <= bubble ? '0 : dec_mem;
      ex_q     <= bubble ? '0 : dec_ex;
      jump_q   <= !bubble && dec_jump;
      jal_q    <= !bubble && dec_jal;
      jr_q     <= !bubble && dec_jr;
      jalr_q   <= !bubble && dec_jalr;
      shift_q  <= !bubble && dec_shift;
      rt_ex_q  <= i_rt;
      halted_q <= (state_d == S_HALT);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end
  assign o_illegal = illegal_q;
`endif

  assign o_ctrl_wb_bus  = wb_q;
  assign o_ctrl_mem_bus = mem_q;
  assign o_ctrl_exc_bus = ex_q;
  assign o_jump         = jump_q;
  assign o_jal          = jal_q;
  assign o_jr           = jr_q;
  assign o_jalr         = jalr_q;
  assign o_shift        = shift_q;
  assign o_pc_write     = pc_write;
  assign o_ifid_write   = ifid_write;
  assign o_halted       = halted_q;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - directed vector bench for control_pipe
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic       flush;
  logic [1:0] wb;
  logic [8:0] mem;
  logic [5:0] exc;
  logic       jump, jal, jr, jalr, shift, pc_w, ifid_w, halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct(funct),
    .i_rs(rs), .i_rt(rt), .i_flush(flush),
    .o_ctrl_wb_bus(wb), .o_ctrl_mem_bus(mem), .o_ctrl_exc_bus(exc),
    .o_jump(jump), .o_jal(jal), .o_jr(jr), .o_jalr(jalr), .o_shift(shift),
    .o_pc_write(pc_w), .o_ifid_write(ifid_w), .o_halted(halted)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .o_illegal(illegal)
`endif
  );

  // fl = {jump, jal, jr, jalr, shift}; en = {pc_write, ifid_write} before the edge
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       flush;
    logic       rst;
    logic [1:0] wb;
    logic [8:0] mem;
    logic [5:0] ex;
    logic [4:0] fl;
    logic [1:0] en;
    logic       h;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r_s,
                     input logic [4:0] r_t, input logic fl_in, input logic rs_in,
                     input logic [1:0] e_wb, input logic [8:0] e_mem, input logic [5:0] e_ex,
                     input logic [4:0] e_fl, input logic [1:0] e_en, input logic e_h);
    vec_t v;
    v.op = op; v.fn = fn; v.rs = r_s; v.rt = r_t; v.flush = fl_in; v.rst = rs_in;
    v.wb = e_wb; v.mem = e_mem; v.ex = e_ex; v.fl = e_fl; v.en = e_en; v.h = e_h;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  // drive at posedge+1, check enables before the edge, registered state after it
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r_s,
                      input logic [4:0] r_t, input logic fl_in, input logic rs_in);
    opcode = op; funct = fn; rs = r_s; rt = r_t; flush = fl_in; rst = rs_in;
    #3;
  endtask

  function automatic logic [31:0] regs();
    return {9'd0, halted, jump, jal, jr, jalr, shift, exc, mem, wb};
  endfunction

  initial begin
    logic [31:0] exp_r;
    int n;
    // reset, then basic decode
    add(6'h23, 6'h00, 5'd0, 5'd0, 0, 1, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b11, 0);
    add(6'h23, 6'h00, 5'd0, 5'd0, 0, 1, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b11, 0);
    add(6'h23, 6'h00, 5'd1, 5'd5, 0, 0, 2'b11, 9'b000000010, 6'b100000, 5'b00000, 2'b11, 0);
    // load-use stall then re-decode
    add(6'h00, 6'h20, 5'd5, 5'd6, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 0);
    add(6'h00, 6'h20, 5'd5, 5'd6, 0, 0, 2'b10, 9'b000000000, 6'b000101, 5'b00000, 2'b11, 0);
    // load to $zero never stalls; flushed BEQ
    add(6'h23, 6'h00, 5'd2, 5'd0, 0, 0, 2'b11, 9'b000000010, 6'b100000, 5'b00000, 2'b11, 0);
    add(6'h00, 6'h20, 5'd0, 5'd0, 0, 0, 2'b10, 9'b000000000, 6'b000101, 5'b00000, 2'b11, 0);
    add(6'h04, 6'h00, 5'd1, 5'd2, 1, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b11, 0);
    // decode table spot checks
    add(6'h00, 6'h00, 5'd0, 5'd3, 0, 0, 2'b10, 9'b000000000, 6'b000101, 5'b00001, 2'b11, 0);
    add(6'h00, 6'h08, 5'd4, 5'd0, 0, 0, 2'b10, 9'b000000000, 6'b000000, 5'b00100, 2'b11, 0);
    add(6'h00, 6'h09, 5'd4, 5'd0, 0, 0, 2'b10, 9'b000000000, 6'b000001, 5'b00010, 2'b11, 0);
    add(6'h28, 6'h00, 5'd1, 5'd2, 0, 0, 2'b00, 9'b100000001, 6'b100000, 5'b00000, 2'b11, 0);
    add(6'h24, 6'h00, 5'd1, 5'd7, 0, 0, 2'b11, 9'b001010010, 6'b100000, 5'b00000, 2'b11, 0);
    add(6'h0D, 6'h00, 5'd1, 5'd2, 0, 0, 2'b10, 9'b000000000, 6'b101010, 5'b00000, 2'b11, 0);
    add(6'h05, 6'h00, 5'd1, 5'd2, 0, 0, 2'b00, 9'b000001000, 6'b100010, 5'b00000, 2'b11, 0);
    add(6'h02, 6'h00, 5'd0, 5'd0, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b10000, 2'b11, 0);
    add(6'h03, 6'h00, 5'd0, 5'd0, 0, 0, 2'b10, 9'b000000000, 6'b000000, 5'b01000, 2'b11, 0);
    add(6'h3E, 6'h00, 5'd0, 5'd0, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b11, 0);
    // flushed HALT is not taken
    add(6'h3F, 6'h00, 5'd0, 5'd0, 1, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b11, 0);
    add(6'h08, 6'h00, 5'd1, 5'd2, 0, 0, 2'b10, 9'b000000000, 6'b100110, 5'b00000, 2'b11, 0);
    // HALT behind a load-use stall, drain, halt, reset out
    add(6'h23, 6'h00, 5'd0, 5'd5, 0, 0, 2'b11, 9'b000000010, 6'b100000, 5'b00000, 2'b11, 0);
    add(6'h3F, 6'h00, 5'd5, 5'd0, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 0);
    add(6'h3F, 6'h00, 5'd5, 5'd0, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 0);
    add(6'h00, 6'h20, 5'd1, 5'd2, 1, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 0);
    add(6'h00, 6'h20, 5'd1, 5'd2, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 0);
    add(6'h00, 6'h20, 5'd1, 5'd2, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 1);
    add(6'h00, 6'h20, 5'd1, 5'd2, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 1);
    add(6'h00, 6'h20, 5'd1, 5'd2, 0, 1, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b11, 0);
    add(6'h00, 6'h20, 5'd1, 5'd2, 0, 0, 2'b10, 9'b000000000, 6'b000101, 5'b00000, 2'b11, 0);
    // reset in the middle of a drain
    add(6'h3F, 6'h00, 5'd1, 5'd2, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 0);
    add(6'h00, 6'h20, 5'd1, 5'd2, 0, 0, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b00, 0);
    add(6'h00, 6'h20, 5'd1, 5'd2, 0, 1, 2'b00, 9'b000000000, 6'b000000, 5'b00000, 2'b11, 0);
    add(6'h23, 6'h00, 5'd0, 5'd5, 0, 0, 2'b11, 9'b000000010, 6'b100000, 5'b00000, 2'b11, 0);

    opcode = '0; funct = '0; rs = '0; rt = '0; flush = 1'b0; rst = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].op, vt[i].fn, vt[i].rs, vt[i].rt, vt[i].flush, vt[i].rst);
      chk("enables", i, {30'd0, pc_w, ifid_w}, {30'd0, vt[i].en});
      @(posedge clk); #1;
      exp_r = {9'd0, vt[i].h, vt[i].fl, vt[i].ex, vt[i].mem, vt[i].wb};
      chk("regs", i, regs(), exp_r);
    end

    // count drain cycles from HALT_OPCODE to o_halted, bounded
    step(6'h3F, 6'h00, 5'd0, 5'd0, 0, 0);
    @(posedge clk); #1;
    n = 0;
    while (!halted && n < 10) begin
      step(6'h00, 6'h20, 5'd1, 5'd2, 0, 0);
      chk("drain_en", n, {30'd0, pc_w, ifid_w}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("drain_len", 0, n, 32'd3);
    step(6'h00, 6'h20, 5'd1, 5'd2, 0, 1);
    @(posedge clk); #1;
    chk("halt_rst", 0, {31'd0, halted}, 32'd0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    step(6'h3E, 6'h00, 5'd0, 5'd0, 0, 0);
    @(posedge clk); #1;
    chk("illegal_hi", 0, {31'd0, illegal}, 32'd1);
    chk("illegal_ctrl", 0, regs(), 32'd0);
    step(6'h00, 6'h20, 5'd1, 5'd2, 0, 0);
    @(posedge clk); #1;
    chk("illegal_lo", 0, {31'd0, illegal}, 32'd0);
    step(6'h3F, 6'h00, 5'd0, 5'd0, 1, 0);
    @(posedge clk); #1;
    chk("illegal_flush", 0, {31'd0, illegal}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
